// File: rtl/ram_sequencer.sv
// rtl/ram_sequencer.sv - scan/edit address and write sequencer for the 4x2 RAM demo
module ram_sequencer_debounce #(
    parameter int DEBOUNCE = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          s1;
    logic          s;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s     <= s1;
            press <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                // Only the rising acceptance strobes; a release is silent.
                press <= s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module ram_sequencer #(
    parameter int N        = 4,
    parameter int M        = 2,
    parameter int DWELL    = 50_000_000,
    parameter int DEBOUNCE = 500_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_mode,
    input  logic         btn_write,
    input  logic [N-1:0] sw_data,
    output logic         WE,
    output logic [M-1:0] A,
    output logic [N-1:0] WD,
    output logic         mode
);
    localparam int DW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        EDIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nx;
    logic [M-1:0]  a_nx;
    logic [N-1:0]  wd_nx;
    logic          mode_press;
    logic          write_press;

    ram_sequencer_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_mode),
        .press (mode_press)
    );

    ram_sequencer_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_write (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_write),
        .press (write_press)
    );

    always_comb begin
        state_nx = state;
        dwell_nx = dwell;
        a_nx     = A;
        wd_nx    = WD;
        case (state)
            SCAN: begin
                // A mode press beats a coinciding dwell step.
                if (mode_press) begin
                    state_nx = EDIT;
                    dwell_nx = '0;
                end else if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    a_nx     = A + M'(1);
                end else begin
                    dwell_nx = dwell + DW'(1);
                end
            end
            EDIT: begin
                if (mode_press) begin
                    state_nx = SCAN;
                    dwell_nx = '0;
                end else if (write_press) begin
                    // Switches are static while the user presses, so a direct sample is safe.
                    state_nx = WRITE;
                    wd_nx    = sw_data;
                end
            end
            WRITE: begin
                state_nx = EDIT;
                a_nx     = A + M'(1);
            end
            default: begin
                state_nx = SCAN;
                dwell_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SCAN;
            dwell <= '0;
            A     <= '0;
            WD    <= '0;
            WE    <= 1'b0;
        end else begin
            state <= state_nx;
            dwell <= dwell_nx;
            A     <= a_nx;
            WD    <= wd_nx;
            WE    <= (state_nx == WRITE);
        end
    end

    assign mode = (state != SCAN);
endmodule
